fifo_ebr_b: RTL and testbench
=============================

FIFO_EBR_B -- requirements
Module: FIFO_EBR_B

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning word width; legal values 2, 4, 8, 16 only; any other value is an elaboration error.
REQ-002 SHALL have parameter DEPTH, default 4096/DATA_WIDTH, meaning FIFO depth in words; fixed as 4096/DATA_WIDTH, so one 4 kbit block RAM.
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-4, meaning the almost-full threshold in words; legal range 1..DEPTH-1.
REQ-004 SHALL have parameter AEMPTY_TH, default 4, meaning the almost-empty threshold in words; legal range 1..DEPTH-1.
REQ-005 SHALL have parameter OUTREG, default "DISABLED", meaning "ENABLED" adds one read-data output register stage.
REQ-006 SHALL have port CK, input, width 1, the single clock; all logic is positive-edge.
REQ-007 SHALL have port RST_N, input, width 1, an asynchronous active-low reset.
REQ-008 SHALL have port WE, input, width 1, the write request.
REQ-009 SHALL have port WDATA, input, width DATA_WIDTH, the write data.
REQ-010 SHALL have port RE, input, width 1, the read request.
REQ-011 SHALL have port RDATA, output, width DATA_WIDTH, the read data.
REQ-012 SHALL have port RVALID, output, width 1, which marks RDATA valid.
REQ-013 SHALL have ports FULL, EMPTY, AFULL and AEMPTY, each output, width 1, as the status flags.
REQ-014 SHALL have port COUNT, output, width log2(DEPTH)+1, the current occupancy in words.
REQ-015 SHALL have ports OVERFLOW and UNDERFLOW, each output, width 1, as single-cycle error pulses.

Function
REQ-016 Storage SHALL be one SB_RAM40_4K, with WRITE_MODE and READ_MODE both set to 0, 1, 2 or 3 for DATA_WIDTH 16, 8, 4 or 2 respectively; MASK is tied to all-zero (all bits written).
REQ-017 Write accept: a write SHALL be accepted when WE=1 and FULL=0; the word is stored at the write pointer, which then increments.
REQ-018 Read accept: a read SHALL be accepted when RE=1 and EMPTY=0; the word at the read pointer is read out, and the read pointer then increments.
REQ-019 Pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without any gap cycle.
REQ-020 With OUTREG="DISABLED", RDATA and RVALID SHALL appear 1 cycle after the accepted read; with "ENABLED", 2 cycles after it.
REQ-021 RVALID SHALL be high for exactly one cycle per accepted read; RDATA holds its value while RVALID=0.
REQ-022 Back-to-back reads SHALL sustain a rate of one word per cycle, with data delivered in write order.
REQ-023 COUNT SHALL be registered: +1 on a write-only accept, -1 on a read-only accept, and unchanged on a simultaneous accept of both or neither.
REQ-024 Simultaneous WE and RE when EMPTY=1: only the write is accepted, UNDERFLOW pulses, and the written word is readable from the next cycle.
REQ-025 Simultaneous WE and RE when FULL=1: only the read is accepted, OVERFLOW pulses, and the write data is dropped.
REQ-026 In all other cases with both requests present, both are accepted in the same cycle.
REQ-027 Flags SHALL be registered and consistent with COUNT in the same cycle, as follows:
- EMPTY = (COUNT==0)
- FULL = (COUNT==DEPTH)
- AFULL = (COUNT>=AFULL_TH)
- AEMPTY = (COUNT<=AEMPTY_TH)
REQ-028 OVERFLOW SHALL pulse high for 1 cycle, on the cycle after any WE while FULL=1; UNDERFLOW SHALL pulse likewise for any RE while EMPTY=1.
REQ-029 A rejected request SHALL NOT modify the pointers, COUNT or memory.
REQ-030 The memory read SHALL be a read-before-write-safe path; a word written in cycle N SHALL NOT be readable before cycle N+1.

Reset
REQ-031 RST_N=0 SHALL asynchronously clear the write pointer, read pointer, COUNT, RDATA, RVALID, FULL, AFULL, OVERFLOW and UNDERFLOW to 0, and set EMPTY and AEMPTY to 1.
REQ-032 Reset release SHALL be sampled synchronously; the first write can be accepted on the first CK edge with RST_N=1.
REQ-033 Memory contents SHALL NOT be cleared by reset; reset mid-operation discards all stored words and any in-flight read, and RVALID is forced to 0.

Verification
REQ-034 Basic write/read with DATA_WIDTH=8, OUTREG="DISABLED": write 0x11, 0x22, 0x33, then read 3 back-to-back -> RVALID high for 3 consecutive cycles with RDATA 0x11, 0x22, 0x33, ending with COUNT=0 and EMPTY=1.
REQ-035 Fill and overflow with DATA_WIDTH=8: write 512 words -> FULL=1, COUNT=512, AFULL asserted from COUNT=508; a 513th write -> OVERFLOW pulses for 1 cycle and COUNT stays 512.
REQ-036 Pointer wrap with DATA_WIDTH=16 (DEPTH 256): 300 streamed writes and reads with simultaneous WE/RE, keeping occupancy at 5 -> in-order data across the pointer wrap, and COUNT constant at 5.
REQ-037 Empty boundary: WE=1 and RE=1 together with EMPTY=1 -> UNDERFLOW pulses, COUNT=1; RE on the next cycle returns the written word.
REQ-038 Output register: OUTREG="ENABLED" -> RVALID appears 2 cycles after the accepted read; an 8-word burst read streams at one word per cycle.
REQ-039 Mid-operation reset: with COUNT=10 and a read in flight, pulse RST_N low for 1 ns -> outputs immediately take the REQ-031 values, and a subsequent write/read of 0xA5 returns 0xA5.

Source files
------------

// File: rtl/fifo_ebr_b.sv
// fifo_ebr_b: single-clock FIFO on one 4 kbit iCE40 block RAM with registered count and status flags
module fifo_ebr_b #(
  parameter int    DATA_WIDTH = 8,
  parameter int    DEPTH      = 4096 / DATA_WIDTH,
  parameter int    AFULL_TH   = DEPTH - 4,
  parameter int    AEMPTY_TH  = 4,
  parameter string OUTREG     = "DISABLED"
) (
  input  logic                      CK,
  input  logic                      RST_N,
  input  logic                      WE,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic                      RE,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic                      RVALID,
  output logic                      FULL,
  output logic                      EMPTY,
  output logic                      AFULL,
  output logic                      AEMPTY,
  output logic [$clog2(DEPTH):0]    COUNT,
  output logic                      OVERFLOW,
  output logic                      UNDERFLOW
);
  localparam int aw = $clog2(DEPTH);
  localparam int cw = aw + 1;
  localparam bit out_en = OUTREG == "ENABLED";

  if (DATA_WIDTH != 2 && DATA_WIDTH != 4 && DATA_WIDTH != 8 && DATA_WIDTH != 16) begin : g_bad_width
    $error("DATA_WIDTH must be 2, 4, 8 or 16");
  end
  if (DEPTH != 4096 / DATA_WIDTH) begin : g_bad_depth
    $error("DEPTH must equal 4096/DATA_WIDTH");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH - 1) begin : g_bad_afull
    $error("AFULL_TH must lie in 1..DEPTH-1");
  end
  if (AEMPTY_TH < 1 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("AEMPTY_TH must lie in 1..DEPTH-1");
  end
  if (OUTREG != "ENABLED" && OUTREG != "DISABLED") begin : g_bad_outreg
    $error("OUTREG must be ENABLED or DISABLED");
  end

  logic [aw-1:0]         wptr, rptr;
  logic [cw-1:0]         cnt_nxt;
  logic [DATA_WIDTH-1:0] ram_q, out_q;
  logic                  wr_ok, rd_ok, rv1, rv2;

  assign wr_ok = WE & ~FULL;
  assign rd_ok = RE & ~EMPTY;

  // occupancy after this cycle; flags are derived from it so they stay aligned with COUNT
  always_comb cnt_nxt = (wr_ok && !rd_ok) ? COUNT + 1'b1 : (rd_ok && !wr_ok) ? COUNT - 1'b1 : COUNT;

  // pointers, occupancy, status flags and error pulses
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      wptr      <= '0;
      rptr      <= '0;
      COUNT     <= '0;
      FULL      <= 1'b0;
      EMPTY     <= 1'b1;
      AFULL     <= 1'b0;
      AEMPTY    <= 1'b1;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      wptr      <= wptr + aw'(wr_ok);
      rptr      <= rptr + aw'(rd_ok);
      COUNT     <= cnt_nxt;
      FULL      <= cnt_nxt == cw'(DEPTH);
      EMPTY     <= cnt_nxt == '0;
      AFULL     <= cnt_nxt >= cw'(AFULL_TH);
      AEMPTY    <= cnt_nxt <= cw'(AEMPTY_TH);
      OVERFLOW  <= WE & FULL;
      UNDERFLOW <= RE & EMPTY;
    end
  end

`ifdef SYNTHESIS
  localparam int ram_mode = DATA_WIDTH == 16 ? 0 : DATA_WIDTH == 8 ? 1 : DATA_WIDTH == 4 ? 2 : 3;
  localparam int stride   = 16 / DATA_WIDTH;
  localparam int lane     = stride == 1 ? 0 : stride / 2 - 1;
  logic [15:0] ram_wd, ram_rd;
  // narrow modes place data bits on every stride-th RAM lane
  always_comb begin
    ram_wd = '0;
    for (int k = 0; k < DATA_WIDTH; k++) ram_wd[stride*k+lane] = WDATA[k];
  end
  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_rd
    assign ram_q[k] = ram_rd[stride*k+lane];
  end
  SB_RAM40_4K #(.WRITE_MODE(ram_mode), .READ_MODE(ram_mode)) u_ram (
    .RDATA(ram_rd), .RADDR(11'(rptr)), .RCLK(CK), .RCLKE(rd_ok), .RE(1'b1),
    .WADDR(11'(wptr)), .WCLK(CK), .WCLKE(wr_ok), .WE(1'b1), .WDATA(ram_wd), .MASK(16'h0000)
  );
`else
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // behavioural block RAM: no reset, registered read clocked only on accepted reads
  always_ff @(posedge CK) begin
    if (wr_ok) mem[wptr] <= WDATA;
    if (rd_ok) ram_q <= mem[rptr];
  end
`endif

  // read-valid pipeline and held output word; RAM output itself cannot be reset
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      rv1   <= 1'b0;
      rv2   <= 1'b0;
      out_q <= '0;
    end else begin
      rv1 <= rd_ok;
      rv2 <= rv1;
      if (rv1) out_q <= ram_q;
    end
  end

  assign RVALID = out_en ? rv2 : rv1;
  assign RDATA  = (!out_en && rv1) ? ram_q : out_q;
endmodule

// File: tb/tb_fifo_ebr_b.sv
// tb_fifo_ebr_b: checks two fifo_ebr_b configurations against a queue-based reference model
module tb_fifo_ebr_b;
  logic        ck = 1'b0, rst_n = 1'b1, we = 1'b0, re = 1'b0;
  logic [15:0] wd = '0;
  logic [7:0]  a_rdata;
  logic [9:0]  a_count;
  logic        a_rvalid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
  logic [15:0] b_rdata;
  logic [8:0]  b_count;
  logic        b_rvalid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;

  always #5 ck = ~ck;

  fifo_ebr_b #(.DATA_WIDTH(8)) dut_a (
    .CK(ck), .RST_N(rst_n), .WE(we), .WDATA(wd[7:0]), .RE(re), .RDATA(a_rdata), .RVALID(a_rvalid),
    .FULL(a_full), .EMPTY(a_empty), .AFULL(a_afull), .AEMPTY(a_aempty), .COUNT(a_count),
    .OVERFLOW(a_ovf), .UNDERFLOW(a_unf)
  );

  fifo_ebr_b #(.DATA_WIDTH(16), .OUTREG("ENABLED")) dut_b (
    .CK(ck), .RST_N(rst_n), .WE(we), .WDATA(wd), .RE(re), .RDATA(b_rdata), .RVALID(b_rvalid),
    .FULL(b_full), .EMPTY(b_empty), .AFULL(b_afull), .AEMPTY(b_aempty), .COUNT(b_count),
    .OVERFLOW(b_ovf), .UNDERFLOW(b_unf)
  );

  int n_tests = 0, n_fail = 0;
  int depth[2] = '{512, 256};
  int lat[2]   = '{1, 2};
  int afth[2]  = '{508, 252};
  logic [15:0] q0[$], q1[$];
  bit          pv[2][2];
  logic [15:0] pd[2][2];
  logic [15:0] hold[2];
  bit          m_ovf[2], m_unf[2];

  task automatic chk(string nm, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int occ(int i);
    return i == 0 ? q0.size() : q1.size();
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      pv[i][0] = 0; pv[i][1] = 0; pd[i][0] = '0; pd[i][1] = '0;
      hold[i] = '0; m_ovf[i] = 0; m_unf[i] = 0;
    end
  endtask

  task automatic model_step(int i, bit w, bit r, logic [15:0] d);
    logic [15:0] q[$];
    logic [15:0] x;
    bit got;
    int n;
    x = '0;
    got = 0;
    if (i == 0) q = q0; else q = q1;
    n = q.size();
    m_ovf[i] = w && n == depth[i];
    m_unf[i] = r && n == 0;
    if (r && n != 0) begin x = q.pop_front(); got = 1; end
    if (w && n != depth[i]) q.push_back(i == 0 ? {8'h00, d[7:0]} : d);
    if (i == 0) q0 = q; else q1 = q;
    pv[i][1] = pv[i][0]; pd[i][1] = pd[i][0];
    pv[i][0] = got;      pd[i][0] = x;
    if (pv[i][lat[i]-1]) hold[i] = pd[i][lat[i]-1];
  endtask

  task automatic check_model();
    chk("a_count",  a_count,  occ(0));
    chk("a_empty",  a_empty,  occ(0) == 0);
    chk("a_full",   a_full,   occ(0) == depth[0]);
    chk("a_afull",  a_afull,  occ(0) >= afth[0]);
    chk("a_aempty", a_aempty, occ(0) <= 4);
    chk("a_ovf",    a_ovf,    m_ovf[0]);
    chk("a_unf",    a_unf,    m_unf[0]);
    chk("a_rvalid", a_rvalid, pv[0][0]);
    chk("a_rdata",  a_rdata,  hold[0]);
    chk("b_count",  b_count,  occ(1));
    chk("b_empty",  b_empty,  occ(1) == 0);
    chk("b_full",   b_full,   occ(1) == depth[1]);
    chk("b_afull",  b_afull,  occ(1) >= afth[1]);
    chk("b_aempty", b_aempty, occ(1) <= 4);
    chk("b_ovf",    b_ovf,    m_ovf[1]);
    chk("b_unf",    b_unf,    m_unf[1]);
    chk("b_rvalid", b_rvalid, pv[1][1]);
    chk("b_rdata",  b_rdata,  hold[1]);
  endtask

  task automatic tick(bit w, bit r, logic [15:0] d);
    we = w; re = r; wd = d;
    @(posedge ck);
    model_step(0, w, r, d);
    model_step(1, w, r, d);
    @(negedge ck);
    check_model();
  endtask

  typedef struct {
    bit       w, r;
    logic [7:0] d;
    bit       ev;
    logic [7:0] ed;
    int       ec;
    bit       ee;
  } vec_t;

  vec_t tv[7];
  int   pw[6] = '{80, 20, 50, 95, 5, 50};
  logic [15:0] v;

  initial begin
    tv[0] = '{1, 0, 8'h11, 0, 8'h00, 1, 0};
    tv[1] = '{1, 0, 8'h22, 0, 8'h00, 2, 0};
    tv[2] = '{1, 0, 8'h33, 0, 8'h00, 3, 0};
    tv[3] = '{0, 1, 8'h00, 1, 8'h11, 2, 0};
    tv[4] = '{0, 1, 8'h00, 1, 8'h22, 1, 0};
    tv[5] = '{0, 1, 8'h00, 1, 8'h33, 0, 1};
    tv[6] = '{0, 0, 8'h00, 0, 8'h33, 0, 1};

    model_reset();
    #1 rst_n = 1'b0;
    @(negedge ck);
    @(negedge ck);
    check_model();
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      tick(tv[k].w, tv[k].r, {8'h00, tv[k].d});
      chk("tbl_rvalid", a_rvalid, tv[k].ev);
      chk("tbl_rdata",  a_rdata,  tv[k].ed);
      chk("tbl_count",  a_count,  tv[k].ec);
      chk("tbl_empty",  a_empty,  tv[k].ee);
    end
    tick(0, 0, 0);

    tick(1, 1, 16'h005A);
    chk("eb_unf", a_unf, 1);
    chk("eb_count", a_count, 1);
    tick(0, 1, 0);
    chk("eb_rvalid", a_rvalid, 1);
    chk("eb_rdata", a_rdata, 8'h5A);
    tick(0, 0, 0);
    chk("eb_unf_clear", a_unf, 0);

    for (int k = 0; k < 8; k++) tick(1, 0, 16'hB000 + 16'(k * 16'h0111));
    for (int k = 0; k < 9; k++) begin
      tick(0, k < 8, 0);
      chk("or_rvalid", b_rvalid, k >= 1);
      if (k >= 1) chk("or_rdata", b_rdata, 16'hB000 + 16'((k - 1) * 16'h0111));
    end
    tick(0, 0, 0);
    chk("or_rvalid_end", b_rvalid, 0);

    v = 16'h1000;
    for (int k = 0; k < 5; k++) begin tick(1, 0, v); v++; end
    for (int k = 0; k < 300; k++) begin
      tick(1, 1, v);
      v++;
      chk("wrap_count", b_count, 5);
      chk("wrap_rvalid", b_rvalid, k >= 1);
    end
    for (int k = 0; k < 7; k++) tick(0, 1, 0);

    for (int k = 1; k <= 512; k++) begin
      tick(1, 0, 16'(k));
      if (k == 507) chk("fill_afull_507", a_afull, 0);
      if (k == 508) chk("fill_afull_508", a_afull, 1);
    end
    chk("fill_full", a_full, 1);
    chk("fill_count", a_count, 512);
    tick(1, 0, 16'h00EE);
    chk("ovf_pulse", a_ovf, 1);
    chk("ovf_count", a_count, 512);
    tick(0, 0, 0);
    chk("ovf_clear", a_ovf, 0);
    chk("ovf_count2", a_count, 512);
    for (int k = 0; k < 514; k++) tick(0, 1, 0);

    for (int p = 0; p < 6; p++)
      for (int k = 0; k < 500; k++)
        tick($urandom_range(0, 99) < pw[p], $urandom_range(0, 99) < 100 - pw[p], 16'($urandom));

    for (int k = 0; k < 600 && (occ(0) != 0 || occ(1) != 0); k++) tick(0, 1, 0);
    chk("drain_a", a_count, 0);
    chk("drain_b", b_count, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);

    for (int k = 0; k < 11; k++) tick(1, 0, 16'(k + 1));
    tick(0, 1, 0);
    chk("mr_count", a_count, 10);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    rst_n = 1'b1;
    @(negedge ck);
    tick(1, 0, 16'h00A5);
    tick(0, 1, 0);
    chk("mr_a_rvalid", a_rvalid, 1);
    chk("mr_a_rdata", a_rdata, 8'hA5);
    tick(0, 0, 0);
    chk("mr_b_rvalid", b_rvalid, 1);
    chk("mr_b_rdata", b_rdata, 16'h00A5);
    tick(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
